// File: rtl/mb_rx_deser.sv
// Mainband receive deserialiser: checks 8-UI valid framing, assembles flits and queues them in a flit FIFO.
// Optional `MB_RX_LANE_REVERSAL_EN` adds lane_rev_i to mirror physical lanes before byte mapping.
module mb_rx_deser #(
    parameter int NUM_LANES  = 16,
    parameter int FLIT_BYTES = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          valid_i,
    input  logic [NUM_LANES-1:0]          data_i,
`ifdef MB_RX_LANE_REVERSAL_EN
    input  logic                          lane_rev_i,
`endif
    input  logic                          flush_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [FLIT_BYTES*8-1:0]       out_data_o,
    output logic                          framing_err_o,
    output logic                          overflow_err_o,
    output logic [7:0]                    drop_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int FLIT_W = FLIT_BYTES * 8;
    localparam int BURSTS = FLIT_BYTES / NUM_LANES;
    localparam int BCW    = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int LW     = AW + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [2:0]        ui_q, ui_d;
    logic [BCW-1:0]    burst_q, burst_d;
    logic [FLIT_W-1:0] flit_q, flit_d;

    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]     count_q, count_d;
    logic              frm_err_q, ovf_err_q;
    logic [7:0]        drop_q;

    logic [NUM_LANES-1:0] lanes;
    logic                 frm_err, flit_done;
    logic                 full, push, pop, ovf_evt, frm_evt;

    // Places one UI of every lane into the partial flit: lane b, UI u, burst k -> byte k*NUM_LANES+b, bit u.
    function automatic logic [FLIT_W-1:0] capture(input logic [FLIT_W-1:0] f,
                                                   input logic [NUM_LANES-1:0] l,
                                                   input logic [BCW-1:0] k,
                                                   input logic [2:0] u);
        logic [FLIT_W-1:0] r;
        r = f;
        for (int b = 0; b < NUM_LANES; b++) begin
            r[(int'(k) * NUM_LANES + b) * 8 + int'(u)] = l[b];
        end
        return r;
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [1:0] inc);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, inc};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

`ifdef MB_RX_LANE_REVERSAL_EN
    always_comb begin
        lanes = '0;
        for (int b = 0; b < NUM_LANES; b++) begin
            lanes[b] = lane_rev_i ? data_i[NUM_LANES-1-b] : data_i[b];
        end
    end
`else
    assign lanes = data_i;
`endif

    // Framing FSM: UIs 0..3 carry valid=1, UIs 4..7 carry valid=0.
    always_comb begin
        state_d   = state_q;
        ui_d      = ui_q;
        burst_d   = burst_q;
        flit_d    = flit_q;
        frm_err   = 1'b0;
        flit_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    flit_d  = capture(flit_q, lanes, burst_q, 3'd0);
                    ui_d    = 3'd1;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (valid_i == (ui_q < 3'd4)) begin
                    flit_d = capture(flit_q, lanes, burst_q, ui_q);
                    if (ui_q == 3'd7) begin
                        ui_d    = 3'd0;
                        state_d = ST_IDLE;
                        if (burst_q == BCW'(BURSTS - 1)) begin
                            burst_d   = '0;
                            flit_done = 1'b1;
                        end else begin
                            burst_d = BCW'(burst_q + 1'b1);
                        end
                    end else begin
                        ui_d = 3'(ui_q + 3'd1);
                    end
                end else begin
                    frm_err = 1'b1;
                    burst_d = '0;
                    ui_d    = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = ST_IDLE;
            ui_d    = 3'd0;
            burst_d = '0;
        end
    end

    // Full check uses occupancy before the edge, so a same-cycle pop never makes room.
    assign full    = (count_q == LW'(FIFO_DEPTH));
    assign push    = flit_done && !full && !flush_i;
    assign ovf_evt = flit_done && full && !flush_i;
    assign frm_evt = frm_err && !flush_i;
    assign pop     = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = LW'(count_q + 1'b1);
        end else if (pop && !push) begin
            count_d = LW'(count_q - 1'b1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ui_q      <= 3'd0;
            burst_q   <= '0;
            flit_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            frm_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            ui_q      <= ui_d;
            burst_q   <= burst_d;
            flit_q    <= flit_d;
            count_q   <= count_d;
            frm_err_q <= frm_evt;
            ovf_err_q <= ovf_evt;
            drop_q    <= sat_add(drop_q, {1'b0, frm_evt} + {1'b0, ovf_evt});
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= AW'(wr_ptr_q + 1'b1);
                if (pop)  rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
            end
        end
    end

    // Flit storage carries no reset; the output is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= flit_d;
    end

    assign out_valid_o    = (count_q != '0);
    assign out_data_o     = out_valid_o ? mem_q[rd_ptr_q] : '0;
    assign fifo_level_o   = count_q;
    assign framing_err_o  = frm_err_q;
    assign overflow_err_o = ovf_err_q;
    assign drop_cnt_o     = drop_q;

endmodule

// File: tb/tb_mb_rx_deser.sv
// Scoreboard bench for mb_rx_deser: expected flits are queued as bursts are driven and popped on handshake.
module tb_mb_rx_deser;

    localparam int NL     = 16;
    localparam int FB     = 64;
    localparam int FD     = 2;
    localparam int FW     = FB * 8;
    localparam int BURSTS = FB / NL;
    localparam int LW     = $clog2(FD) + 1;

    logic          clk;
    logic          reset_n;
    logic          valid_i;
    logic [NL-1:0] data_i;
    logic          flush_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [FW-1:0] out_data_o;
    logic          framing_err_o;
    logic          overflow_err_o;
    logic [7:0]    drop_cnt_o;
    logic [LW-1:0] fifo_level_o;
`ifdef MB_RX_LANE_REVERSAL_EN
    logic          lane_rev_i;
`endif

    mb_rx_deser #(.NUM_LANES(NL), .FLIT_BYTES(FB), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .valid_i        (valid_i),
        .data_i         (data_i),
`ifdef MB_RX_LANE_REVERSAL_EN
        .lane_rev_i     (lane_rev_i),
`endif
        .flush_i        (flush_i),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_data_o     (out_data_o),
        .framing_err_o  (framing_err_o),
        .overflow_err_o (overflow_err_o),
        .drop_cnt_o     (drop_cnt_o),
        .fifo_level_o   (fifo_level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            fr_cnt   = 0;
    int            ov_cnt   = 0;
    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] exp_flit;
    bit            lane_rev_m = 1'b0;

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: pops on handshake, checks stability under stall, counts error pulses.
    initial begin
        logic [FW-1:0] held;
        bit            holding;
        holding = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid_o) begin
                if (holding) chk("stall_stable", out_data_o, held);
                if (out_ready_i && !flush_i) begin
                    if (sb_q.size() == 0) chk("unexpected_pop", FW'(out_valid_o), FW'(0));
                    else                  chk("flit_data", out_data_o, sb_q.pop_front());
                    holding = 1'b0;
                end else begin
                    held    = out_data_o;
                    holding = 1'b1;
                end
            end else begin
                holding = 1'b0;
            end
            if (framing_err_o)  fr_cnt++;
            if (overflow_err_o) ov_cnt++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic ui(input logic v, input logic [NL-1:0] d);
        valid_i = v;
        data_i  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic burst(input int k, input bit rnd, input logic [NL-1:0] fixed);
        logic [NL-1:0] d;
        for (int u = 0; u < 8; u++) begin
            d = rnd ? NL'($urandom) : fixed;
            for (int b = 0; b < NL; b++) begin
                exp_flit[(k * NL + b) * 8 + u] = d[lane_rev_m ? NL - 1 - b : b];
            end
            ui(u < 4, d);
        end
        valid_i = 1'b0;
    endtask

    task automatic send_flit(input bit accept, input bit rnd, input logic [NL-1:0] fixed);
        exp_flit = '0;
        for (int k = 0; k < BURSTS; k++) burst(k, rnd, fixed);
        if (accept) sb_q.push_back(exp_flit);
    endtask

    initial begin
        logic [FW-1:0] kflit;
        int            fr0, ov0;
        reset_n     = 1'b0;
        valid_i     = 1'b0;
        data_i      = '0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
`ifdef MB_RX_LANE_REVERSAL_EN
        lane_rev_i  = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", FW'(out_valid_o), FW'(0));
        chk("rst_level", FW'(fifo_level_o), FW'(0));
        chk("rst_data", out_data_o, FW'(0));
        chk("rst_drop", FW'(drop_cnt_o), FW'(0));
        chk("rst_errs", FW'({framing_err_o, overflow_err_o}), FW'(0));
        reset_n = 1'b1;
        idle(2);

        // Lane 0 high on every UI: bytes 0,16,32,48 become FF.
        kflit = '0;
        for (int k = 0; k < BURSTS; k++) kflit[(k * NL) * 8 +: 8] = 8'hFF;
        chk("t1_pre_valid", FW'(out_valid_o), FW'(0));
        send_flit(1'b1, 1'b0, NL'(1));
        chk("t1_valid", FW'(out_valid_o), FW'(1));
        chk("t1_level", FW'(fifo_level_o), FW'(1));
        chk("t1_const", out_data_o, kflit);
        out_ready_i = 1'b1;
        idle(3);
        chk("t1_level0", FW'(fifo_level_o), FW'(0));
        chk("t1_drained", FW'(sb_q.size()), FW'(0));

        // Framing violation at UI2 after one good burst.
        fr0 = fr_cnt;
        exp_flit = '0;
        burst(0, 1'b1, '0);
        ui(1'b1, NL'($urandom));
        ui(1'b1, NL'($urandom));
        ui(1'b0, NL'($urandom));
        idle(2);
        chk("t2_frm_pulse", FW'(fr_cnt), FW'(fr0 + 1));
        chk("t2_drop", FW'(drop_cnt_o), FW'(1));
        chk("t2_noflit", FW'(out_valid_o), FW'(0));
        send_flit(1'b1, 1'b1, '0);
        idle(3);
        chk("t2_drained", FW'(sb_q.size()), FW'(0));

        // Backpressure: three back-to-back flits into a two-entry FIFO.
        out_ready_i = 1'b0;
        ov0 = ov_cnt;
        fr0 = fr_cnt;
        send_flit(1'b1, 1'b1, '0);
        send_flit(1'b1, 1'b1, '0);
        send_flit(1'b0, 1'b1, '0);
        idle(2);
        chk("t3_level", FW'(fifo_level_o), FW'(2));
        chk("t3_ovf_pulse", FW'(ov_cnt), FW'(ov0 + 1));
        chk("t3_drop", FW'(drop_cnt_o), FW'(2));
        chk("t3_no_frm", FW'(fr_cnt), FW'(fr0));
        out_ready_i = 1'b1;
        idle(4);
        chk("t3_drained", FW'(sb_q.size()), FW'(0));
        chk("t3_level0", FW'(fifo_level_o), FW'(0));

        // Flush with one flit queued and a partial flit in progress.
        out_ready_i = 1'b0;
        ov0 = ov_cnt;
        fr0 = fr_cnt;
        send_flit(1'b0, 1'b1, '0);
        idle(1);
        chk("t4_level1", FW'(fifo_level_o), FW'(1));
        exp_flit = '0;
        burst(0, 1'b1, '0);
        burst(1, 1'b1, '0);
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("t4_level0", FW'(fifo_level_o), FW'(0));
        chk("t4_valid0", FW'(out_valid_o), FW'(0));
        idle(2);
        chk("t4_no_err", FW'((fr_cnt - fr0) + (ov_cnt - ov0)), FW'(0));
        chk("t4_drop", FW'(drop_cnt_o), FW'(2));
        out_ready_i = 1'b1;
        send_flit(1'b1, 1'b1, '0);
        idle(3);
        chk("t4_drained", FW'(sb_q.size()), FW'(0));

        // Drop counter saturation via repeated UI1 violations.
        for (int i = 0; i < 260; i++) begin
            ui(1'b1, '0);
            ui(1'b0, '0);
        end
        idle(2);
        chk("t5_drop_sat", FW'(drop_cnt_o), FW'(255));

        // Asynchronous reset in the middle of the third burst with a flit queued.
        out_ready_i = 1'b0;
        send_flit(1'b0, 1'b1, '0);
        exp_flit = '0;
        burst(0, 1'b1, '0);
        burst(1, 1'b1, '0);
        for (int u = 0; u < 4; u++) ui(1'b1, NL'($urandom));
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_valid", FW'(out_valid_o), FW'(0));
        chk("t6_level", FW'(fifo_level_o), FW'(0));
        chk("t6_data", out_data_o, FW'(0));
        chk("t6_drop", FW'(drop_cnt_o), FW'(0));
        chk("t6_errs", FW'({framing_err_o, overflow_err_o}), FW'(0));
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);
        out_ready_i = 1'b1;
        send_flit(1'b1, 1'b1, '0);
        idle(3);
        chk("t6_drained", FW'(sb_q.size()), FW'(0));
        chk("t6_drop_after", FW'(drop_cnt_o), FW'(0));

`ifdef MB_RX_LANE_REVERSAL_EN
        // Reversed lanes: physical lane 0 maps to logical lane 15.
        lane_rev_i = 1'b1;
        lane_rev_m = 1'b1;
        kflit = '0;
        for (int k = 0; k < BURSTS; k++) kflit[(k * NL + NL - 1) * 8 +: 8] = 8'hFF;
        out_ready_i = 1'b0;
        send_flit(1'b1, 1'b0, NL'(1));
        chk("t7_rev_const", out_data_o, kflit);
        out_ready_i = 1'b1;
        idle(3);
        chk("t7_drained", FW'(sb_q.size()), FW'(0));
`endif

        chk("sb_final", FW'(sb_q.size()), FW'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
